// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_responder_pkg;

  localparam int DM_BYTES_PER_WORD = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_resp_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  w_mask;
    logic [63:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_responder_sram.sv
// Single-port 64-bit word array, one 8-bit lane per byte enable.
// Read data is registered at the access edge; a same-word write returns the old contents.
module dm_sram
  import dm_responder_pkg::*;
#(
  parameter int IDX_W = 13
) (
  input  logic             clk,
  input  logic             en,
  input  logic [7:0]       w_mask,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  for (genvar b = 0; b < DM_BYTES_PER_WORD; b++) begin : g_lane
    logic [7:0] mem [2**IDX_W];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en) begin
        q <= mem[idx];
        if (w_mask[b]) mem[idx] <= wdata[8*b +: 8];
      end
    end

    assign rdata[8*b +: 8] = q;
  end

endmodule

// File: rtl/dm_responder.sv
// Load/store-side data-memory slave: one request at a time, byte-masked writes,
// doubleword reads, response returned LATENCY cycles after accept.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_w_mask,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("dm_responder: LATENCY must be in 1..15");
  end

  dm_resp_state_t state;
  dm_req_t        req;
  logic [3:0]     cnt;
  logic           rd_q, err_q;
  logic [63:0]    sram_q;
  logic           in_range, accept;

  assign req      = '{addr: req_addr, w_mask: req_w_mask, wdata: req_wdata};
  // Full 64-bit compare so high addresses never alias into the array.
  assign in_range = (req.addr >> ADDR_W) == 64'd0;
  assign req_ready = (state == IDLE) & ~rst;
  assign accept   = req_valid & req_ready;

  // The array is only touched at accept, so its read register holds the
  // sampled word untouched until the response completes.
  dm_sram #(.IDX_W(ADDR_W - 3)) u_sram (
    .clk    (clk),
    .en     (accept & in_range),
    .w_mask (req.w_mask),
    .idx    (req.addr[ADDR_W-1:3]),
    .wdata  (req.wdata),
    .rdata  (sram_q)
  );

  assign resp_rdata = (resp_valid & rd_q) ? sram_q : '0;
  assign resp_err   = resp_valid & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      cnt        <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rd_q  <= in_range && (req.w_mask == 8'h00);
          err_q <= !in_range;
          if (LATENCY == 1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 2);
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          rd_q       <= 1'b0;
          err_q      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
